matmul_seq_engine: RTL and testbench
====================================

// Module: matmul_seq_engine
// PURPOSE
//  Parametrised successor to the single-mode matrix walker. Streams through an N x N result
//  grid in row-major order. For each (row, col) it requests matrix row A[row] and column
//  B[col] from the matrix buffer. In MUL mode it computes the dot product with one MAC per
//  cycle; in pass modes it forwards A or B elements. Sits between the matrix storage/loader
//  and the result writer/UART output path.
// PARAMETERS
//  N      32                          matrix dimension (rows = cols = vector length), N >= 2
//  DW     8                           unsigned element width
//  IDXW   $clog2(N)                   row/col index width
//  ACCW   2*DW+$clog2(N)              result width (full-precision dot product, never overflows)
// PORTS
//  clk_in      in   1         clock
//  rst_in      in   1         async reset, active-high
//  start       in   1         begin run; acted on only in IDLE
//  mode        in   2         latched at start: 0=PASS_A, 1=PASS_B, 2=MUL, 3=reserved (start ignored)
//  abort       in   1         synchronous abort of a run in progress
//  matA_row    in   N*DW      packed [N-1:0][DW-1:0], row vector A[row_in][*]
//  matB_col    in   N*DW      packed [N-1:0][DW-1:0], column vector B[*][col_in]
//  row_in      in   IDXW      row index tagged on returned data
//  col_in      in   IDXW      col index tagged on returned data
//  val_rows    in   1         returned data valid
//  new_request out  1         one-cycle request strobe
//  row_req     out  IDXW      requested row
//  col_req     out  IDXW      requested col
//  row_out     out  IDXW      result row
//  col_out     out  IDXW      result col
//  matrix_val  out  ACCW      result value (pass modes: element zero-extended)
//  valid_out   out  1         one-cycle result strobe
//  busy        out  1         high in any state except IDLE
//  done        out  1         sticky run-complete flag; cleared by the next accepted start
// BEHAVIOUR
//  Reset (async): every output 0, FSM=IDLE, counters and accumulator 0, mode reg=0.
//  FSM: IDLE -> REQ -> WAIT -> (MAC) -> EMIT -> REQ | IDLE.
//  IDLE: start && mode!=3 -> latch mode, row/col counters=0, done<=0, go to REQ.
//        start while busy is ignored.
//  REQ (1 cycle): new_request=1, row_req/col_req=current counters; next state WAIT.
//  WAIT: accept only val_rows && row_in==row_req && col_in==col_req.
//        Mismatched or early val_rows is dropped; no timeout. On accept, latch matA_row and matB_col.
//        MUL -> MAC with k=0, acc=0. PASS_A -> EMIT with value A[col]. PASS_B -> EMIT with value B[row].
//  MAC: acc += A[k]*B[k], unsigned, ACCW bits, k=0..N-1 over exactly N cycles; then EMIT.
//  EMIT (1 cycle): valid_out=1, row_out/col_out=counters, matrix_val=acc or element.
//        If col==N-1 && row==N-1: done<=1, IDLE.
//        Else if col==N-1: col=0, row+=1, REQ. Else: col+=1, REQ.
//  Latency (accept cycle to valid_out): PASS = 1 cycle; MUL = N+1 cycles.
//  Per element: PASS = 3 cycles + memory wait; MUL = N+3 cycles + memory wait.
//  valid_out/new_request are strobes, 0 outside EMIT/REQ; row_out/col_out/matrix_val hold last value.
//  abort (any non-IDLE state, priority over all transitions): next state IDLE.
//        No valid_out that cycle, done stays 0, counters reset to 0.
//  abort in IDLE: no effect. start && abort in the same IDLE cycle: start wins.
//  Reset asserted mid-run: outputs to 0 immediately; a pending returned response is discarded.
// TESTING (bench N=4, DW=8)
//  1 PASS_A, A[r][c]=4r+c, memory 2-cycle latency -> 16 valid_out in order (0,0)..(3,3);
//    matrix_val=4r+c; done=1 after (3,3); busy=0.
//  2 MUL, A=identity, B[r][c]=r+c -> matrix_val(r,c)=r+c; valid_out exactly 5 cycles after each accept.
//  3 MUL, all elements 255 -> every matrix_val = 260100 (0x3F804), no truncation in 18-bit ACCW.
//  4 WAIT requesting (1,2); drive val_rows with (1,3) then (1,2) -> first dropped;
//    single valid_out at (1,2).
//  5 abort in MAC of element (2,1) -> IDLE next cycle, no valid_out, done=0;
//    new start with mode=1 restarts at (0,0).
//  6 start with mode=3 -> stays IDLE. start pulsed mid-run -> ignored.
//    rst_in mid-MAC -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/matmul_seq_engine.sv
// Purpose: walks an N x N result grid row-major; per cell fetches A[row]/B[col], emits the dot product (MUL) or a forwarded element (PASS_A/PASS_B).
// Latency: accept-to-valid_out is 1 cycle in pass modes and N+1 cycles in MUL; per cell 3 (pass) or N+3 (MUL) cycles plus memory wait.
// Backpressure: none on the result side; waits indefinitely in WAIT for a response tagged with the requested row/col, dropping any other.
module matmul_seq_engine #(
    parameter int N    = 32,
    parameter int DW   = 8,
    parameter int IDXW = $clog2(N),
    parameter int ACCW = 2*DW + $clog2(N)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic                   abort,
    input  logic [N-1:0][DW-1:0]   matA_row,
    input  logic [N-1:0][DW-1:0]   matB_col,
    input  logic [IDXW-1:0]        row_in,
    input  logic [IDXW-1:0]        col_in,
    input  logic                   val_rows,
    output logic                   new_request,
    output logic [IDXW-1:0]        row_req,
    output logic [IDXW-1:0]        col_req,
    output logic [IDXW-1:0]        row_out,
    output logic [IDXW-1:0]        col_out,
    output logic [ACCW-1:0]        matrix_val,
    output logic                   valid_out,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_MAC,
        S_EMIT
    } state_t;

    localparam logic [1:0]      M_PASS_A = 2'd0;
    localparam logic [1:0]      M_MUL    = 2'd2;
    localparam logic [1:0]      M_RSVD   = 2'd3;
    localparam logic [IDXW-1:0] LAST     = IDXW'(N - 1);

    state_t                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [IDXW-1:0]        row_q, row_d;
    logic [IDXW-1:0]        col_q, col_d;
    logic [IDXW-1:0]        k_q, k_d;
    logic [ACCW-1:0]        acc_q, acc_d;
    logic [N-1:0][DW-1:0]   a_q, a_d;
    logic [N-1:0][DW-1:0]   b_q, b_d;
    logic [IDXW-1:0]        row_out_q, row_out_d;
    logic [IDXW-1:0]        col_out_q, col_out_d;
    logic [ACCW-1:0]        val_q, val_d;
    logic                   done_q, done_d;
    logic [ACCW-1:0]        prod;
    logic                   tag_match;

    // State and datapath registers; everything clears asynchronously on reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            row_out_q <= '0;
            col_out_q <= '0;
            val_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            row_q     <= row_d;
            col_q     <= col_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            row_out_q <= row_out_d;
            col_out_q <= col_out_d;
            val_q     <= val_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: cell walk, response matching, MAC and result capture, abort override
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        row_d     = row_q;
        col_d     = col_q;
        k_d       = k_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        row_out_d = row_out_q;
        col_out_d = col_out_q;
        val_d     = val_q;
        done_d    = done_q;
        prod      = ACCW'(a_q[k_q]) * ACCW'(b_q[k_q]);
        tag_match = val_rows && (row_in == row_q) && (col_in == col_q);

        case (state_q)
            S_IDLE: begin
                if (start && (mode != M_RSVD)) begin
                    mode_d  = mode;
                    row_d   = '0;
                    col_d   = '0;
                    done_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tag_match) begin
                    a_d = matA_row;
                    b_d = matB_col;
                    if (mode_q == M_MUL) begin
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = S_MAC;
                    end else begin
                        // Pass modes publish the selected element straight away
                        row_out_d = row_q;
                        col_out_d = col_q;
                        val_d     = (mode_q == M_PASS_A) ? ACCW'(matA_row[col_q])
                                                         : ACCW'(matB_col[row_q]);
                        state_d   = S_EMIT;
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod;
                k_d   = k_q + 1'b1;
                if (k_q == LAST) begin
                    row_out_d = row_q;
                    col_out_d = col_q;
                    val_d     = acc_d;
                    state_d   = S_EMIT;
                end
            end
            S_EMIT: begin
                if (col_q == LAST) begin
                    col_d = '0;
                    if (row_q == LAST) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = S_REQ;
                    end
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every transition of a running walk and suppresses any result capture
        if ((state_q != S_IDLE) && abort) begin
            state_d   = S_IDLE;
            row_d     = '0;
            col_d     = '0;
            k_d       = '0;
            done_d    = done_q;
            row_out_d = row_out_q;
            col_out_d = col_out_q;
            val_d     = val_q;
        end
    end

    // Strobes decode straight from the state so reset clears them immediately
    always_comb begin
        new_request = (state_q == S_REQ);
        valid_out   = (state_q == S_EMIT);
        busy        = (state_q != S_IDLE);
        row_req     = row_q;
        col_req     = col_q;
        row_out     = row_out_q;
        col_out     = col_out_q;
        matrix_val  = val_q;
        done        = done_q;
    end

endmodule

// File: tb/tb_matmul_seq_engine.sv
// Purpose: self-checking bench for matmul_seq_engine at N=4, DW=8 with a latency-configurable memory responder.
// Latency: checks accept-to-result latency per mode against the expected table value.
// Backpressure: responder answers each request after a set delay, optionally preceded by a mis-tagged response.
module tb_matmul_seq_engine;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int IDXW = 2;
    localparam int ACCW = 18;

    logic                  clk_in = 1'b0;
    logic                  rst_in = 1'b1;
    logic                  start  = 1'b0;
    logic [1:0]            mode   = 2'd0;
    logic                  abort  = 1'b0;
    logic [N-1:0][DW-1:0]  matA_row = '0;
    logic [N-1:0][DW-1:0]  matB_col = '0;
    logic [IDXW-1:0]       row_in = '0;
    logic [IDXW-1:0]       col_in = '0;
    logic                  val_rows = 1'b0;
    logic                  new_request;
    logic [IDXW-1:0]       row_req, col_req, row_out, col_out;
    logic [ACCW-1:0]       matrix_val;
    logic                  valid_out, busy, done;

    matmul_seq_engine #(.N(N), .DW(DW), .IDXW(IDXW), .ACCW(ACCW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .mode(mode), .abort(abort),
        .matA_row(matA_row), .matB_col(matB_col), .row_in(row_in), .col_in(col_in),
        .val_rows(val_rows), .new_request(new_request), .row_req(row_req), .col_req(col_req),
        .row_out(row_out), .col_out(col_out), .matrix_val(matrix_val), .valid_out(valid_out),
        .busy(busy), .done(done)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { int due; int r; int c; bit good; } pend_t;
    typedef struct { int r; int c; longint v; int cyc; } out_t;
    typedef struct { logic [1:0] md; int lat; int pat; int exp_lat; int exp_cnt; bit bogus; bit glitch; } vec_t;

    int     A [N][N];
    int     B [N][N];
    pend_t  pend[$];
    out_t   outs[$];
    int     accs[$];
    int     cyc = 0;
    int     lat_cur = 1;
    bit     bogus_on = 1'b0;
    int     n_chk = 0;
    int     n_fail = 0;
    vec_t   vecs[7];

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Memory side: drive queued responses; only correctly tagged ones count as accepts
    always @(posedge clk_in) begin
        #1;
        cyc++;
        val_rows = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            pend_t e;
            e = pend.pop_front();
            val_rows = 1'b1;
            row_in   = IDXW'(e.r);
            col_in   = IDXW'(e.c);
            for (int j = 0; j < N; j++) begin
                matA_row[j] = DW'(A[e.r][j]);
                matB_col[j] = DW'(B[j][e.c]);
            end
            if (e.good) accs.push_back(cyc);
        end
    end

    // Observe requests and results mid-cycle
    always @(negedge clk_in) begin
        if (new_request) begin
            if (bogus_on && row_req == 2'd1 && col_req == 2'd2) begin
                pend.push_back('{cyc + lat_cur, 1, 3, 1'b0});
                pend.push_back('{cyc + lat_cur + 1, 1, 2, 1'b1});
            end else begin
                pend.push_back('{cyc + lat_cur, int'(row_req), int'(col_req), 1'b1});
            end
        end
        if (valid_out) outs.push_back('{int'(row_out), int'(col_out), longint'(matrix_val), cyc});
    end

    function automatic longint model(input int md, input int r, input int c);
        longint s;
        if (md == 0) return A[r][c];
        if (md == 1) return B[r][c];
        s = 0;
        for (int k = 0; k < N; k++) s += A[r][k] * B[k][c];
        return s;
    endfunction

    task automatic set_pattern(input int p);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                case (p)
                    0: begin A[r][c] = 4*r + c; B[r][c] = $urandom_range(0, 255); end
                    1: begin A[r][c] = (r == c) ? 1 : 0; B[r][c] = r + c; end
                    2: begin A[r][c] = 255; B[r][c] = 255; end
                    default: begin A[r][c] = $urandom_range(0, 255); B[r][c] = $urandom_range(0, 255); end
                endcase
            end
    endtask

    task automatic clear_q();
        pend.delete();
        outs.delete();
        accs.delete();
    endtask

    task automatic run_test(input vec_t v, input string tag);
        bit fin;
        int m;
        set_pattern(v.pat);
        lat_cur  = v.lat;
        bogus_on = v.bogus;
        clear_q();
        @(posedge clk_in); #1;
        start = 1'b1; mode = v.md;
        @(posedge clk_in); #1;
        start = 1'b0;
        chk({tag, "_busy_start"}, busy, 1);
        chk({tag, "_done_clr"}, done, 0);
        fin = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk_in); #1;
            start = v.glitch && (i == 20);
            mode  = (v.glitch && i == 20) ? 2'd2 : v.md;
            if (done) begin fin = 1'b1; break; end
        end
        start = 1'b0;
        if (!fin) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: done not seen within budget", tag);
        end
        chk({tag, "_count"}, outs.size(), v.exp_cnt);
        m = (outs.size() < v.exp_cnt) ? outs.size() : v.exp_cnt;
        for (int i = 0; i < m; i++) begin
            chk({tag, "_row"}, outs[i].r, i / N);
            chk({tag, "_col"}, outs[i].c, i % N);
            chk({tag, "_val"}, outs[i].v, model(int'(v.md), i / N, i % N));
            if (i < accs.size()) chk({tag, "_lat"}, outs[i].cyc - accs[i], v.exp_lat);
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        bogus_on = 1'b0;
    endtask

    initial begin
        bit seen;
        vecs[0] = '{2'd0, 2, 0, 1, 16, 1'b0, 1'b0};
        vecs[1] = '{2'd2, 2, 1, 5, 16, 1'b0, 1'b0};
        vecs[2] = '{2'd2, 1, 2, 5, 16, 1'b0, 1'b0};
        vecs[3] = '{2'd0, 1, 0, 1, 16, 1'b1, 1'b0};
        vecs[4] = '{2'd0, 3, 3, 1, 16, 1'b0, 1'b1};
        vecs[5] = '{2'd1, int'($urandom_range(1, 4)), 3, 1, 16, 1'b0, 1'b0};
        vecs[6] = '{2'd2, int'($urandom_range(1, 4)), 3, 5, 16, 1'b0, 1'b0};

        // Reset state
        #2;
        chk("reset_outs", {busy, valid_out, new_request, done, row_out, col_out, row_req, col_req, matrix_val}, 0);
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;

        for (int t = 0; t < 7; t++) begin
            run_test(vecs[t], $sformatf("vec%0d", t));
            if (t == 2) chk("mul255_val", outs[N*N-1].v, 260100);
        end

        // Reserved mode is ignored
        clear_q();
        @(posedge clk_in); #1;
        start = 1'b1; mode = 2'd3;
        @(posedge clk_in); #1;
        start = 1'b0;
        repeat (4) @(negedge clk_in);
        chk("mode3_busy", busy, 0);
        chk("mode3_noreq", pend.size(), 0);

        // Abort while multiplying cell (2,1)
        set_pattern(3);
        lat_cur = 1;
        clear_q();
        @(posedge clk_in); #1;
        start = 1'b1; mode = 2'd2;
        @(posedge clk_in); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_in);
            if (new_request && row_req == 2'd2 && col_req == 2'd1) begin seen = 1'b1; break; end
        end
        chk("abort_req_seen", seen, 1);
        repeat (3) @(posedge clk_in);
        #1 abort = 1'b1;
        @(posedge clk_in); #1 abort = 1'b0;
        @(negedge clk_in);
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid_out, 0);
        chk("abort_done", done, 0);
        repeat (8) @(negedge clk_in);
        chk("abort_outcount", outs.size(), 9);
        run_test('{2'd1, 2, 3, 1, 16, 1'b0, 1'b0}, "after_abort");

        // Reset in the middle of a MAC
        set_pattern(2);
        lat_cur = 1;
        clear_q();
        @(posedge clk_in); #1;
        start = 1'b1; mode = 2'd2;
        @(posedge clk_in); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_in);
            if (outs.size() > 0 && new_request) begin seen = 1'b1; break; end
        end
        chk("rstmid_req_seen", seen, 1);
        repeat (2) @(posedge clk_in);
        #2;
        chk("rstmid_pre_val", matrix_val, 260100);
        rst_in = 1'b1;
        #1;
        chk("rstmid_outs", {busy, valid_out, new_request, done, row_out, col_out, row_req, col_req, matrix_val}, 0);
        @(posedge clk_in); #1 rst_in = 1'b0;
        pend.delete();
        repeat (3) @(negedge clk_in);
        chk("rstmid_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
